// File: rtl/turn_signal_conditioner.sv
// turn_signal_conditioner
// Synchronises and debounces the raw left/right/hazard switches, resolves them
// into one lamp mode (hazard has priority, left+right counts as hazard), and
// inserts a blank GAP between two different active modes. Also produces the
// step_tick pacing pulse, re-phased whenever an active mode is entered.
module turn_signal_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic clock,
  input  logic reset_b,
  input  logic left_sw,
  input  logic right_sw,
  input  logic hazard_sw,
  output logic InL,
  output logic InR,
  output logic InH,
  output logic step_tick
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEFT   = 3'd1,
    ST_RIGHT  = 3'd2,
    ST_HAZARD = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  // Bit order for the per-switch vectors: 0 = left, 1 = right, 2 = hazard.
  logic [2:0] raw_sw;
  logic [2:0] deb_bits;

  assign raw_sw = {hazard_sw, right_sw, left_sw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      logic          meta_q;
      logic          sync_q;
      logic          deb_q;
      logic          deb_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Debounce: filtered bit follows sync only after DEBOUNCE_CYCLES
      // consecutive disagreeing samples; any agreement restarts the count.
      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q != deb_q) begin
          if (cnt_q == DEB_LAST) begin
            deb_d = sync_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Two-flop synchroniser plus debounce state registers.
      always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
          deb_q  <= 1'b0;
          cnt_q  <= '0;
        end else begin
          meta_q <= raw_sw[gi];
          sync_q <= meta_q;
          deb_q  <= deb_d;
          cnt_q  <= cnt_d;
        end
      end

      assign deb_bits[gi] = deb_q;
    end
  endgenerate

  state_e        state_q;
  state_e        state_d;
  state_e        resolved;
  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;
  logic          tick_now;
  logic          enter_active;

  assign tick_now = (tick_q == TICK_LAST);

  // Resolve debounced switches into a single requested mode (ST_IDLE = none).
  always_comb begin
    resolved = ST_IDLE;
    if (deb_bits[2] || (deb_bits[0] && deb_bits[1])) begin
      resolved = ST_HAZARD;
    end else if (deb_bits[0]) begin
      resolved = ST_LEFT;
    end else if (deb_bits[1]) begin
      resolved = ST_RIGHT;
    end
  end

  // Mode FSM next-state: changes between two active modes pass through GAP,
  // which is left on a tick (to the freshly resolved mode) or at once on NONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = resolved;
      end
      ST_LEFT, ST_RIGHT, ST_HAZARD: begin
        if (resolved == ST_IDLE) begin
          state_d = ST_IDLE;
        end else if (resolved != state_q) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (resolved == ST_IDLE) begin
          state_d = ST_IDLE;
        end else if (tick_now) begin
          state_d = resolved;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign enter_active = ((state_q == ST_IDLE) || (state_q == ST_GAP)) &&
                        ((state_d == ST_LEFT) || (state_d == ST_RIGHT) ||
                         (state_d == ST_HAZARD));

  // Tick counter free-runs, but restarts at 0 when an active mode is entered
  // so the first lamp step is always a full TICK_DIV period away.
  always_comb begin
    tick_d = tick_now ? '0 : tick_q + 1'b1;
    if (enter_active) begin
      tick_d = '0;
    end
  end

  // State and tick registers.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  assign InL       = (state_q == ST_LEFT);
  assign InR       = (state_q == ST_RIGHT);
  assign InH       = (state_q == ST_HAZARD);
  assign step_tick = tick_now;

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Randomised bench for turn_signal_conditioner: switch patterns with random
// hold lengths (including short glitches) and occasional async reset pulses,
// checked every cycle against an edge-counting behavioural model.
module tb_turn_signal_conditioner;

  localparam int DC = 4;
  localparam int TD = 8;

  logic clock = 1'b0;
  logic reset_b = 1'b0;
  logic left_sw = 1'b0;
  logic right_sw = 1'b0;
  logic hazard_sw = 1'b0;
  logic InL, InR, InH, step_tick;

  int checks = 0;
  int failures = 0;

  turn_signal_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .TICK_DIV(TD)
  ) dut (
    .clock(clock),
    .reset_b(reset_b),
    .left_sw(left_sw),
    .right_sw(right_sw),
    .hazard_sw(hazard_sw),
    .InL(InL),
    .InR(InR),
    .InH(InH),
    .step_tick(step_tick)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got={tick,H,R,L}=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  // Reference model. Mode codes: 0 none/idle, 1 left, 2 right, 3 hazard, 4 gap.
  // n counts clock edges since reset; the tick phase is (n - anchor) mod TD,
  // with anchor moved to the edge at which an active mode is entered.
  int m_n = 0;
  int m_anchor = 0;
  int m_mode = 0;
  int m_last_agree [3] = '{0, 0, 0};
  bit m_s1 [3] = '{0, 0, 0};
  bit m_s2 [3] = '{0, 0, 0};
  bit m_deb [3] = '{0, 0, 0};

  function automatic int want_mode(bit l, bit r, bit h);
    if (h || (l && r)) return 3;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  function automatic bit model_tick(int n, int anchor);
    return ((n - anchor) % TD) == (TD - 1);
  endfunction

  always @(posedge clock or negedge reset_b) begin : model
    int  want;
    int  next_mode;
    int  e;
    bit  raw [3];
    if (!reset_b) begin
      m_n = 0;
      m_anchor = 0;
      m_mode = 0;
      for (int i = 0; i < 3; i++) begin
        m_last_agree[i] = 0;
        m_s1[i] = 0;
        m_s2[i] = 0;
        m_deb[i] = 0;
      end
    end else begin
      raw[0] = left_sw;
      raw[1] = right_sw;
      raw[2] = hazard_sw;
      e = m_n + 1;
      want = want_mode(m_deb[0], m_deb[1], m_deb[2]);
      next_mode = m_mode;
      if (m_mode == 0) next_mode = want;
      else if (m_mode == 4) begin
        if (want == 0) next_mode = 0;
        else if (model_tick(m_n, m_anchor)) next_mode = want;
      end else if (want == 0) next_mode = 0;
      else if (want != m_mode) next_mode = 4;
      if ((m_mode == 0 || m_mode == 4) && next_mode >= 1 && next_mode <= 3) m_anchor = e;
      // A debounced bit flips once sync has disagreed with it on DC edges in a row.
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] == m_deb[i]) m_last_agree[i] = e;
        else if (e - m_last_agree[i] == DC) begin
          m_deb[i] = m_s2[i];
          m_last_agree[i] = e;
        end
      end
      for (int i = 0; i < 3; i++) begin
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
      m_mode = next_mode;
      m_n = e;
    end
  end

  // Compare all outputs against the model once per cycle, away from posedge.
  always @(negedge clock) begin
    logic [3:0] exp_v;
    exp_v = {model_tick(m_n, m_anchor) && reset_b, m_mode == 3, m_mode == 2, m_mode == 1};
    check_eq(reset_b ? "outs" : "outs_in_reset", {step_tick, InH, InR, InL}, exp_v);
  end

  task automatic set_sw(input logic [2:0] v);
    left_sw = v[0];
    right_sw = v[1];
    hazard_sw = v[2];
  endtask

  initial begin
    logic [2:0] pat;
    int         len;
    // Reset held while the switches toggle every cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      set_sw((i % 2 == 0) ? 3'b111 : 3'b000);
    end
    @(negedge clock);
    set_sw(3'b000);
    reset_b = 1'b1;
    repeat (20) @(negedge clock);
    // Directed: left held, then left+right together, then right released.
    set_sw(3'b001);
    repeat (25) @(negedge clock);
    set_sw(3'b011);
    repeat (25) @(negedge clock);
    set_sw(3'b001);
    repeat (25) @(negedge clock);
    // Random segments, mixing glitch-length and long holds.
    for (int seg = 0; seg < 160; seg++) begin
      pat = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) pat[2] = 1'b0;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
      set_sw(pat);
      repeat (len) @(negedge clock);
      if ($urandom_range(0, 19) == 0) begin
        // Half-cycle async reset pulse between the negedge and next posedge.
        #1 reset_b = 1'b0;
        #2 check_eq("async_clear", {step_tick, InH, InR, InL}, 4'b0000);
        #1 reset_b = 1'b1;
        @(negedge clock);
      end
    end
    set_sw(3'b000);
    repeat (20) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
